// File: rtl/sram_arbiter_pkg.sv
// Shared encodings for the external memory port arbiter.
// The later AXI bridge reuses the state and owner encodings.
package sram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arbState_t;

  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

endpackage

// File: rtl/sram_arbiter.sv
// Arbitrates the single SRAM-like port between instruction fetch and data access,
// one outstanding transaction at a time, with in-flight fetch discard on flush.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  input  logic                inst_flush,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                inst_done,
  output logic                inst_stall,
  input  logic                data_req,
  input  logic                data_wr,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_done,
  output logic                data_stall,
  output logic                mem_req,
  output logic                mem_wr,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata
);

  arbState_t state, nextState;
  logic      owner;
  logic      discard;
  logic      grantData, grantInst, flushHit, complete;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: if (grantData || grantInst) nextState = REQ;
      REQ:  if (mem_addr_ok) nextState = mem_data_ok ? IDLE : WAIT;
      WAIT: if (mem_data_ok) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // A requester whose done is pulsing is masked so grants alternate under contention.
  always_comb begin
    grantData = 1'b0;
    grantInst = 1'b0;
    flushHit  = 1'b0;
    complete  = 1'b0;
    mem_req   = 1'b0;
    if (state == IDLE) begin
      grantData = data_req && !data_done;
      grantInst = !grantData && inst_req && !inst_done && !inst_flush;
    end
    if (state == REQ) mem_req = 1'b1;
    flushHit = inst_flush && (owner == OWN_INST) && (state != IDLE);
    complete = mem_data_ok && ((state == WAIT) || ((state == REQ) && mem_addr_ok));
  end

  assign inst_stall = inst_req && !inst_done;
  assign data_stall = data_req && !data_done;

  // The request latch doubles as the mem_* drivers, so they stay stable until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner      <= OWN_INST;
      discard    <= 1'b0;
      mem_wr     <= 1'b0;
      mem_wstrb  <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      inst_done  <= 1'b0;
      data_done  <= 1'b0;
      inst_rdata <= '0;
      data_rdata <= '0;
    end else begin
      inst_done <= 1'b0;
      data_done <= 1'b0;
      if (grantData) begin
        owner     <= OWN_DATA;
        mem_wr    <= data_wr;
        mem_wstrb <= data_wstrb;
        mem_addr  <= data_addr;
        mem_wdata <= data_wdata;
      end else if (grantInst) begin
        owner     <= OWN_INST;
        mem_wr    <= 1'b0;
        mem_wstrb <= '0;
        mem_addr  <= inst_addr;
        mem_wdata <= '0;
      end
      if (complete) begin
        discard <= 1'b0;
        if (owner == OWN_DATA) begin
          data_done <= 1'b1;
          if (!mem_wr) data_rdata <= mem_rdata;
        end else if (!(discard || flushHit)) begin
          inst_done  <= 1'b1;
          inst_rdata <= mem_rdata;
        end
      end else if (flushHit) begin
        discard <= 1'b1;
      end
    end
  end

  // A response without a prior address acceptance is a slave protocol error.
  property noStrayDataOk;
    @(posedge clk) disable iff (rst)
      mem_data_ok |-> ((state == WAIT) || ((state == REQ) && mem_addr_ok));
  endproperty
  assert property (noStrayDataOk);

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: a per-cycle vector table for load and contention,
// plus hand-written store/backpressure, flush and mid-transaction reset sequences.
module tb_sram_arbiter;

  logic        clk, rst;
  logic        inst_req, inst_flush, inst_done, inst_stall;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_done, data_stall;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int total = 0;
  int bad = 0;

  sram_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_flush(inst_flush),
    .inst_rdata(inst_rdata), .inst_done(inst_done), .inst_stall(inst_stall),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_done(data_done), .data_stall(data_stall),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
    .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct packed {
    logic        instReq;
    logic        dataReq;
    logic [31:0] dataAddr;
    logic        addrOk;
    logic        dataOk;
    logic [31:0] rdata;
    logic        expMemReq;
    logic [31:0] expMemAddr;
    logic        expInstDone;
    logic        expDataDone;
    logic        expInstStall;
    logic        expDataStall;
    logic [31:0] expInstRdata;
    logic [31:0] expDataRdata;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    inst_req    = v.instReq;
    data_req    = v.dataReq;
    data_addr   = v.dataAddr;
    mem_addr_ok = v.addrOk;
    mem_data_ok = v.dataOk;
    mem_rdata   = v.rdata;
    #1;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    chk($sformatf("vec%0d.mem_req", idx),    {31'd0, mem_req},    {31'd0, v.expMemReq});
    chk($sformatf("vec%0d.mem_addr", idx),   mem_addr,            v.expMemAddr);
    chk($sformatf("vec%0d.inst_done", idx),  {31'd0, inst_done},  {31'd0, v.expInstDone});
    chk($sformatf("vec%0d.data_done", idx),  {31'd0, data_done},  {31'd0, v.expDataDone});
    chk($sformatf("vec%0d.inst_stall", idx), {31'd0, inst_stall}, {31'd0, v.expInstStall});
    chk($sformatf("vec%0d.data_stall", idx), {31'd0, data_stall}, {31'd0, v.expDataStall});
    chk($sformatf("vec%0d.inst_rdata", idx), inst_rdata,          v.expInstRdata);
    chk($sformatf("vec%0d.data_rdata", idx), data_rdata,          v.expDataRdata);
  endtask

  initial begin
    // iR dR dAddr addrOk dataOk rdata | memReq memAddr iDone dDone iStall dStall iRdata dRdata
    vecs[0]  = '{1'b0, 1'b1, 32'h1000, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,    1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h0};
    vecs[1]  = '{1'b0, 1'b1, 32'h1000, 1'b1, 1'b0, 32'h0,        1'b1, 32'h1000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h0};
    vecs[2]  = '{1'b0, 1'b1, 32'h1000, 1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h1000, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0,        32'h0};
    vecs[3]  = '{1'b0, 1'b1, 32'h1000, 1'b0, 1'b0, 32'h0,        1'b0, 32'h1000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        32'hDEADBEEF};
    vecs[4]  = '{1'b1, 1'b1, 32'h2000, 1'b0, 1'b0, 32'h0,        1'b0, 32'h1000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,        32'hDEADBEEF};
    vecs[5]  = '{1'b1, 1'b1, 32'h2000, 1'b1, 1'b0, 32'h0,        1'b1, 32'h2000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,        32'hDEADBEEF};
    vecs[6]  = '{1'b1, 1'b1, 32'h2000, 1'b0, 1'b1, 32'h11112222, 1'b0, 32'h2000, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0,        32'hDEADBEEF};
    vecs[7]  = '{1'b1, 1'b1, 32'h2000, 1'b0, 1'b0, 32'h0,        1'b0, 32'h2000, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        32'h11112222};
    vecs[8]  = '{1'b1, 1'b0, 32'h2000, 1'b1, 1'b1, 32'hCAFEF00D, 1'b1, 32'h100,  1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        32'h11112222};
    vecs[9]  = '{1'b1, 1'b0, 32'h2000, 1'b0, 1'b0, 32'h0,        1'b0, 32'h100,  1'b1, 1'b0, 1'b0, 1'b0, 32'hCAFEF00D, 32'h11112222};
    vecs[10] = '{1'b0, 1'b0, 32'h2000, 1'b0, 1'b0, 32'h0,        1'b0, 32'h100,  1'b0, 1'b0, 1'b0, 1'b0, 32'hCAFEF00D, 32'h11112222};

    rst = 1'b1;
    inst_req = 1'b0; inst_flush = 1'b0; inst_addr = 32'h100;
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    chk("reset.mem_req",    {31'd0, mem_req},   32'h0);
    chk("reset.mem_addr",   mem_addr,           32'h0);
    chk("reset.inst_done",  {31'd0, inst_done}, 32'h0);
    chk("reset.data_done",  {31'd0, data_done}, 32'h0);
    chk("reset.data_rdata", data_rdata,         32'h0);
    rst = 1'b0;

    // Single load, then contention with data first and inst granted in data's done cycle
    for (int i = 0; i < 11; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end

    // Store with address backpressure held for five cycles
    @(negedge clk);
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b0011; data_wdata = 32'h12345678;
    data_addr = 32'h3000; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    #1;
    chk("store.idle_mem_req", {31'd0, mem_req}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk($sformatf("store.bp%0d.mem_req", i),   {31'd0, mem_req},    32'h1);
      chk($sformatf("store.bp%0d.mem_addr", i),  mem_addr,            32'h3000);
      chk($sformatf("store.bp%0d.mem_wr", i),    {31'd0, mem_wr},     32'h1);
      chk($sformatf("store.bp%0d.mem_wstrb", i), {28'd0, mem_wstrb},  32'h3);
      chk($sformatf("store.bp%0d.mem_wdata", i), mem_wdata,           32'h12345678);
      chk($sformatf("store.bp%0d.stall", i),     {31'd0, data_stall}, 32'h1);
    end
    @(negedge clk); mem_addr_ok = 1'b1; #1;
    chk("store.accept.mem_req", {31'd0, mem_req}, 32'h1);
    @(negedge clk); mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h77777777; #1;
    chk("store.wait.mem_req", {31'd0, mem_req}, 32'h0);
    @(negedge clk); mem_data_ok = 1'b0; #1;
    chk("store.data_done",  {31'd0, data_done},  32'h1);
    chk("store.data_rdata", data_rdata,          32'h11112222);
    chk("store.data_stall", {31'd0, data_stall}, 32'h0);
    @(negedge clk); data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0; #1;
    chk("store.done_clear", {31'd0, data_done}, 32'h0);

    // Fetch flushed while waiting for the response
    @(negedge clk); inst_req = 1'b1; inst_addr = 32'hBFC00000; #1;
    chk("flush.inst_stall", {31'd0, inst_stall}, 32'h1);
    @(negedge clk); mem_addr_ok = 1'b1; #1;
    chk("flush.mem_addr", mem_addr,         32'hBFC00000);
    chk("flush.mem_wr",   {31'd0, mem_wr},  32'h0);
    @(negedge clk); mem_addr_ok = 1'b0; inst_flush = 1'b1; #1;
    chk("flush.wait.mem_req", {31'd0, mem_req}, 32'h0);
    @(negedge clk); inst_flush = 1'b0; inst_req = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hAAAA5555; #1;
    @(negedge clk); mem_data_ok = 1'b0; data_req = 1'b1; data_addr = 32'h5000; #1;
    chk("flush.no_inst_done", {31'd0, inst_done}, 32'h0);
    chk("flush.inst_rdata",   inst_rdata,         32'hCAFEF00D);
    @(negedge clk); mem_addr_ok = 1'b1; mem_data_ok = 1'b1; mem_rdata = 32'h0BADF00D; #1;
    chk("flush.idle_regrant.mem_req",  {31'd0, mem_req}, 32'h1);
    chk("flush.idle_regrant.mem_addr", mem_addr,         32'h5000);
    @(negedge clk); mem_addr_ok = 1'b0; mem_data_ok = 1'b0; #1;
    chk("merged.data_done",  {31'd0, data_done}, 32'h1);
    chk("merged.data_rdata", data_rdata,         32'h0BADF00D);
    chk("merged.inst_done",  {31'd0, inst_done}, 32'h0);
    @(negedge clk); data_req = 1'b0; #1;

    // Reset while a store waits for its response
    @(negedge clk);
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'hF; data_wdata = 32'hA5A5A5A5; data_addr = 32'h6000; #1;
    @(negedge clk); mem_addr_ok = 1'b1; #1;
    chk("rstwait.mem_wdata", mem_wdata, 32'hA5A5A5A5);
    @(negedge clk); mem_addr_ok = 1'b0; rst = 1'b1; #1;
    @(negedge clk); rst = 1'b0; data_req = 1'b0; data_wr = 1'b0; data_wstrb = 4'h0; #1;
    chk("rstwait.mem_req",    {31'd0, mem_req},   32'h0);
    chk("rstwait.mem_wr",     {31'd0, mem_wr},    32'h0);
    chk("rstwait.mem_wstrb",  {28'd0, mem_wstrb}, 32'h0);
    chk("rstwait.mem_addr",   mem_addr,           32'h0);
    chk("rstwait.mem_wdata2", mem_wdata,          32'h0);
    chk("rstwait.inst_rdata", inst_rdata,         32'h0);
    chk("rstwait.data_rdata", data_rdata,         32'h0);
    chk("rstwait.data_done",  {31'd0, data_done}, 32'h0);
    @(negedge clk); #1;
    chk("rstwait.no_done_after", {31'd0, data_done}, 32'h0);
    chk("rstwait.idle_mem_req",  {31'd0, mem_req},   32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
